sevenseg_mux: RTL
=================

SEVENSEG_MUX -- requirements
Module: sevenseg_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000, clock cycles per digit slot; legal minimum 2.
REQ-003 Parameter BLANK_CYCLES, default 500, anti-ghosting dark cycles at the start of each slot; legal range 0..REFRESH_DIV-1.
REQ-004 clk  input  1  single system clock; all state on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 data  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, digit 0 least significant.
REQ-007 dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 blank_in  input  NUM_DIGITS  per-digit force-dark mask, 1 = dark.
REQ-009 lzs_en  input  1  leading-zero suppression enable.
REQ-010 load  input  1  single-cycle strobe capturing data, dp_in, blank_in and lzs_en into the shadow set.
REQ-011 seg  output  7  active-low segments, bit 6 = g ... bit 0 = a.
REQ-012 dp_n  output  1  active-low decimal point.
REQ-013 an  output  NUM_DIGITS  active-low digit enables, at most one bit low.
REQ-014 frame_start  output  1  one-cycle pulse when digit 0's slot begins.

Function
REQ-015 Slot counter div_cnt SHALL count 0..REFRESH_DIV-1 and wrap; digit index SHALL advance on the wrap, going NUM_DIGITS-1 -> 0.
REQ-016 frame_start SHALL be high for exactly the one cycle in which div_cnt = 0 and the digit index = 0.
REQ-017 load SHALL write the shadow set and set a pending flag on the same edge.
REQ-018 When pending is set and the cycle is div_cnt = REFRESH_DIV-1 with digit index = NUM_DIGITS-1, the shadow set SHALL copy to the active set and pending SHALL clear (frame-boundary update, no tearing).
REQ-019 A load on the transfer cycle SHALL bypass directly to the active set and leave pending clear.
REQ-020 Loads arriving while pending is set SHALL overwrite the shadow set; the last one wins.
REQ-021 Hex decode (active-low, g..a): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18, A=08, b=03, c=27, d=21, E=06, F=0E.
REQ-022 Leading-zero suppression is evaluated on the active set when active lzs_en=1.
- Scanning from digit NUM_DIGITS-1 downward, each zero nibble above the highest nonzero nibble SHALL be dark.
- Digit 0 is never suppressed.
- dp_in of a suppressed digit still drives dp_n.
REQ-023 A dark digit (blank, or suppressed) SHALL drive seg = 7F; its an bit stays per REQ-024.
REQ-024 an bit for the current digit SHALL be low only when div_cnt >= BLANK_CYCLES, else an = all ones.
REQ-025 seg, dp_n, an and frame_start SHALL be registered; each reflects the div_cnt and digit state of the previous cycle (1-cycle latency).
REQ-026 While an = all ones, seg SHALL be 7F and dp_n SHALL be 1.
REQ-027 With NUM_DIGITS = 1, the digit index is constant 0 and every slot wrap is a frame boundary.

Reset
REQ-028 Asserting reset_n low SHALL immediately force:
- seg = 7F, dp_n = 1, an = all ones, frame_start = 0;
- div_cnt = 0, digit index = 0, pending = 0;
- shadow and active data/dp = 0, lzs_en = 0, blank = all ones (dark until first transfer).
REQ-029 Reset asserted mid-frame SHALL abandon any pending load; the first clock after deassertion starts at digit 0, div_cnt 0.

Structure
REQ-030 Package sevenseg_pkg SHALL hold the 16-entry segment constant table, SEG_OFF = 7'h7F, and the parameter-legality limits.
REQ-031 Sub-module sevenseg_decode (combinational nibble -> 7-bit active-low) SHALL be instantiated once on the selected nibble.
REQ-032 Illegal parameters SHALL fail elaboration.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-033 Reset held low -> an=F, seg=7F, dp_n=1, frame_start=0; no digit lights after release until a load is transferred.
REQ-034 load data=12AF, blank=0, dp=0010 -> after the next frame boundary: slot0 an=E seg=0E; slot1 an=D seg=08 dp_n=0; slot2 an=B seg=24; slot3 an=7 seg=79.
REQ-035 lzs_en=1, data=0050 -> digits 3,2 dark, digit1 seg=12, digit0 seg=40; data=0000 -> only digit0 lit with seg=40.
REQ-036 load during slot 1 -> outputs unchanged through slot 3; new value shown from the next frame_start; a second load before the boundary wins.
REQ-037 Check every slot -> an=F for the first 2 cycles and exactly one bit low for the remaining 6; frame_start period = 32 cycles.
REQ-038 reset_n pulsed low mid-slot2 with a load pending -> outputs dark immediately; after release scanning restarts at digit 0 and the pending data is never displayed.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared constants for the multiplexed seven-segment display driver.
package sevenseg_pkg;

  // All segments dark (active-low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Parameter legality limits.
  localparam int unsigned MIN_DIGITS      = 1;
  localparam int unsigned MAX_DIGITS      = 8;
  localparam int unsigned MIN_REFRESH_DIV = 2;

  // Active-low hex glyphs, bit 6 = g ... bit 0 = a, indexed by nibble value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
  };

  // True when the digit count, slot length and blanking length are usable.
  function automatic bit params_legal(input int unsigned nd,
                                      input int unsigned rd,
                                      input int unsigned bc);
    return (nd >= MIN_DIGITS) && (nd <= MAX_DIGITS) &&
           (rd >= MIN_REFRESH_DIV) && (bc < rd);
  endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  // Table lookup of the glyph for the selected nibble.
  always_comb begin
    seg_c = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/sevenseg_mux.sv
// Time-multiplexed seven-segment driver with shadow/active display sets,
// frame-boundary updates, anti-ghosting blanking and leading-zero suppression.
module sevenseg_mux
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lzs_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LIT   = CNT_W'(BLANK_CYCLES);
  localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

  // Reject unusable parameter sets at elaboration.
  if (!params_legal(NUM_DIGITS, REFRESH_DIV, BLANK_CYCLES)) begin : g_param_check
    $error("sevenseg_mux: illegal NUM_DIGITS/REFRESH_DIV/BLANK_CYCLES");
  end

  logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
  logic [DIG_W-1:0]      dig_q, dig_d;
  logic                  pending_q, pending_d;
  logic [DATA_W-1:0]     sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic                  sh_lzs_q, sh_lzs_d, act_lzs_q, act_lzs_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_start_q, frame_start_d;

  logic                  slot_end, frame_end;
  logic [3:0]            sel_nib;
  logic                  sel_dp, sel_blank, sel_supp, zero_run;
  logic [6:0]            dec_seg_c;

  // Slot/digit scan counters and shadow-to-active transfer at the frame boundary.
  always_comb begin
    div_cnt_d   = div_cnt_q + CNT_W'(1);
    dig_d       = dig_q;
    pending_d   = pending_q;
    sh_data_d   = sh_data_q;
    sh_dp_d     = sh_dp_q;
    sh_blank_d  = sh_blank_q;
    sh_lzs_d    = sh_lzs_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    act_lzs_d   = act_lzs_q;
    slot_end    = (div_cnt_q == CNT_LAST);
    frame_end   = slot_end && (dig_q == DIG_LAST);

    if (slot_end) begin
      div_cnt_d = '0;
      dig_d     = (dig_q == DIG_LAST) ? '0 : dig_q + DIG_W'(1);
    end

    if (load) begin
      sh_data_d  = data;
      sh_dp_d    = dp_in;
      sh_blank_d = blank_in;
      sh_lzs_d   = lzs_en;
    end

    if (frame_end) begin
      pending_d = 1'b0;
      if (load) begin
        act_data_d  = data;
        act_dp_d    = dp_in;
        act_blank_d = blank_in;
        act_lzs_d   = lzs_en;
      end else if (pending_q) begin
        act_data_d  = sh_data_q;
        act_dp_d    = sh_dp_q;
        act_blank_d = sh_blank_q;
        act_lzs_d   = sh_lzs_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Select the current digit and decide whether leading-zero suppression darkens it.
  always_comb begin
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    sel_supp  = 1'b0;
    zero_run  = act_lzs_q;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_data_q[4*i +: 4] == 4'h0);
      if (DIG_W'(i) == dig_q) begin
        sel_nib   = act_data_q[4*i +: 4];
        sel_dp    = act_dp_q[i];
        sel_blank = act_blank_q[i];
        sel_supp  = zero_run && (i != 0);
      end
    end
  end

  sevenseg_decode u_decode (
    .nibble (sel_nib),
    .seg_c  (dec_seg_c)
  );

  // Next output values; everything stays dark during the blanking window.
  always_comb begin
    seg_d         = SEG_OFF;
    dp_n_d        = 1'b1;
    an_d          = '1;
    frame_start_d = (div_cnt_q == '0) && (dig_q == '0);
    if (div_cnt_q >= CNT_LIT) begin
      an_d   = ~(NUM_DIGITS'(1) << dig_q);
      seg_d  = (sel_blank || sel_supp) ? SEG_OFF : dec_seg_c;
      dp_n_d = !(sel_dp && !sel_blank);
    end
  end

  // State and output registers; reset leaves the display dark until a transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q     <= '0;
      dig_q         <= '0;
      pending_q     <= 1'b0;
      sh_data_q     <= '0;
      sh_dp_q       <= '0;
      sh_blank_q    <= '1;
      sh_lzs_q      <= 1'b0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      act_lzs_q     <= 1'b0;
      seg_q         <= SEG_OFF;
      dp_n_q        <= 1'b1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      dig_q         <= dig_d;
      pending_q     <= pending_d;
      sh_data_q     <= sh_data_d;
      sh_dp_q       <= sh_dp_d;
      sh_blank_q    <= sh_blank_d;
      sh_lzs_q      <= sh_lzs_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      act_lzs_q     <= act_lzs_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule
